imm_gen_stage: RTL and testbench

Registered, parametrised immediate-generation stage for the pipelined RISC-V core, between instruction fetch/decode and execute. Extracts and sign- or zero-extends the immediate of every base encoding plus shift-amount and CSR-zimm forms, to XLEN bits. Carries a sideband tag alongside. Provides a valid/ready handshake with a 2-entry skid buffer, and supports pipeline flush.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/imm_extract.sv | 61 ++++++
 rtl/imm_gen_stage.sv | 121 ++++++++++++
 tb/tb_imm_gen_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants: immediate format selects and default XLEN.
package riscv_pkg;

   localparam int DEFAULT_XLEN = 32;

   localparam logic [2:0] IMM_I     = 3'b000;
   localparam logic [2:0] IMM_S     = 3'b001;
   localparam logic [2:0] IMM_B     = 3'b010;
   localparam logic [2:0] IMM_J     = 3'b011;
   localparam logic [2:0] IMM_U     = 3'b100;
   localparam logic [2:0] IMM_SHAMT = 3'b101;
   localparam logic [2:0] IMM_ZIMM  = 3'b110;
   localparam logic [2:0] IMM_ZERO  = 3'b111;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction and extension for all base formats.
module imm_extract
   import riscv_pkg::*;
#(
   parameter int XLEN = DEFAULT_XLEN
) (
   input  logic [31:0]      inst,
   input  logic [2:0]       imm_src,
   output logic [XLEN-1:0]  imm,
   output logic             illegal
);

   // Sign-extending formats are first assembled as 32-bit signed values and
   // then widened, so the same expressions serve both XLEN=32 and XLEN=64.
   logic signed [31:0] sext32;

   // Select the format and extend to XLEN.
   always_comb begin
      sext32  = '0;
      imm     = '0;
      illegal = 1'b0;
      unique case (imm_src)
         IMM_I: begin
            sext32 = {{20{inst[31]}}, inst[31:20]};
            imm    = XLEN'(sext32);
         end
         IMM_S: begin
            sext32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            imm    = XLEN'(sext32);
         end
         IMM_B: begin
            sext32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            imm    = XLEN'(sext32);
         end
         IMM_J: begin
            sext32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            imm    = XLEN'(sext32);
         end
         IMM_U: begin
            sext32 = {inst[31:12], 12'b0};
            imm    = XLEN'(sext32);
         end
         IMM_SHAMT: begin
            // RV32 shifts only have a 5-bit amount; bit 25 set is reserved.
            if (XLEN == 64) begin
               imm = XLEN'({26'b0, inst[25:20]});
            end else begin
               imm     = XLEN'({27'b0, inst[24:20]});
               illegal = inst[25];
            end
         end
         IMM_ZIMM: begin
            imm = XLEN'({27'b0, inst[19:15]});
         end
         default: begin
            imm = '0;
         end
      endcase
   end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a 2-entry skid buffer and flush.
module imm_gen_stage
   import riscv_pkg::*;
#(
   parameter int XLEN  = DEFAULT_XLEN,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [2:0]       in_imm_src,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal
);

   logic [XLEN-1:0]  ext_imm;
   logic             ext_illegal;

   logic             main_valid_q, main_valid_d;
   logic [XLEN-1:0]  main_imm_q,   main_imm_d;
   logic [TAG_W-1:0] main_tag_q,   main_tag_d;
   logic             main_ill_q,   main_ill_d;
   logic             skid_valid_q, skid_valid_d;
   logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
   logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
   logic             skid_ill_q,   skid_ill_d;

   logic             accept;
   logic             emit;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .inst    (in_inst),
      .imm_src (in_imm_src),
      .imm     (ext_imm),
      .illegal (ext_illegal)
   );

   // in_ready is purely registered state, so no combinational path from out_ready.
   assign in_ready    = !skid_valid_q;
   assign out_valid   = main_valid_q;
   assign out_imm     = main_imm_q;
   assign out_tag     = main_tag_q;
   assign out_illegal = main_ill_q;

   assign accept = in_valid && in_ready;
   assign emit   = main_valid_q && out_ready;

   // Next-state for the main/skid pair; flush clears only the valid bits.
   always_comb begin
      main_valid_d = main_valid_q;
      main_imm_d   = main_imm_q;
      main_tag_d   = main_tag_q;
      main_ill_d   = main_ill_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_tag_d   = skid_tag_q;
      skid_ill_d   = skid_ill_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (emit) begin
         if (skid_valid_q) begin
            // in_ready is low here, so no accept can coincide with this move.
            main_imm_d   = skid_imm_q;
            main_tag_d   = skid_tag_q;
            main_ill_d   = skid_ill_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_imm_d   = ext_imm;
            main_tag_d   = in_tag;
            main_ill_d   = ext_illegal;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!main_valid_q) begin
            main_valid_d = 1'b1;
            main_imm_d   = ext_imm;
            main_tag_d   = in_tag;
            main_ill_d   = ext_illegal;
         end else begin
            skid_valid_d = 1'b1;
            skid_imm_d   = ext_imm;
            skid_tag_d   = in_tag;
            skid_ill_d   = ext_illegal;
         end
      end
   end

   // Register the main entry; its data is visible on the outputs, so it resets to zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         main_imm_q   <= '0;
         main_tag_q   <= '0;
         main_ill_q   <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         main_valid_q <= main_valid_d;
         main_imm_q   <= main_imm_d;
         main_tag_q   <= main_tag_d;
         main_ill_q   <= main_ill_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   // Skid data is never observed while its valid bit is clear, so it needs no reset.
   always_ff @(posedge clk) begin
      skid_imm_q <= skid_imm_d;
      skid_tag_q <= skid_tag_d;
      skid_ill_q <= skid_ill_d;
   end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_gen_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_inst;
   logic [2:0]  in_imm_src;
   logic [7:0]  in_tag;
   logic        out_ready;

   logic        r32_in_ready, r32_out_valid, r32_out_illegal;
   logic [31:0] r32_out_imm;
   logic [7:0]  r32_out_tag;
   logic        r64_in_ready, r64_out_valid, r64_out_illegal;
   logic [63:0] r64_out_imm;
   logic [7:0]  r64_out_tag;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] inst;
      logic [2:0]  src;
      logic [7:0]  tag;
   } entry_t;

   entry_t     model_q[$];
   logic [7:0] emitted[$];
   bit         last_acc;

   always #5 clk = ~clk;

   imm_gen_stage #(.XLEN(32), .TAG_W(8)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(r32_in_ready), .in_inst(in_inst), .in_imm_src(in_imm_src),
      .in_tag(in_tag), .out_valid(r32_out_valid), .out_ready(out_ready),
      .out_imm(r32_out_imm), .out_tag(r32_out_tag), .out_illegal(r32_out_illegal)
   );

   imm_gen_stage #(.XLEN(64), .TAG_W(8)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(r64_in_ready), .in_inst(in_inst), .in_imm_src(in_imm_src),
      .in_tag(in_tag), .out_valid(r64_out_valid), .out_ready(out_ready),
      .out_imm(r64_out_imm), .out_tag(r64_out_tag), .out_illegal(r64_out_illegal)
   );

   // Reference immediate value, computed as plain integer arithmetic.
   function automatic logic [63:0] ref_imm(logic [31:0] i, logic [2:0] s, int xlen);
      longint v;
      case (s)
         3'd0: begin v = longint'(i[31:20]); if (i[31]) v -= 4096; end
         3'd1: begin v = longint'({i[31:25], i[11:7]}); if (i[31]) v -= 4096; end
         3'd2: begin v = longint'({i[31], i[7], i[30:25], i[11:8]}) * 2; if (i[31]) v -= 8192; end
         3'd3: begin v = longint'({i[31], i[19:12], i[20], i[30:21]}) * 2; if (i[31]) v -= 64'd2097152; end
         3'd4: begin v = longint'(i[31:12]) * 4096; if (i[31]) v -= 64'h1_0000_0000; end
         3'd5: v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
         3'd6: v = longint'(i[19:15]);
         default: v = 0;
      endcase
      if (xlen == 32) return {32'b0, v[31:0]};
      return v;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Compare both DUTs against the queue model: occupancy and the head entry.
   task automatic check_model();
      int n;
      n = model_q.size();
      chk("v32", 64'(r32_out_valid), 64'(n > 0));
      chk("v64", 64'(r64_out_valid), 64'(n > 0));
      chk("rdy32", 64'(r32_in_ready), 64'(n < 2));
      chk("rdy64", 64'(r64_in_ready), 64'(n < 2));
      if (n > 0) begin
         chk("tag32", 64'(r32_out_tag), 64'(model_q[0].tag));
         chk("tag64", 64'(r64_out_tag), 64'(model_q[0].tag));
         chk("imm32", 64'(r32_out_imm), ref_imm(model_q[0].inst, model_q[0].src, 32));
         chk("imm64", r64_out_imm, ref_imm(model_q[0].inst, model_q[0].src, 64));
         chk("ill32", 64'(r32_out_illegal),
             64'(model_q[0].src == 3'd5 && model_q[0].inst[25]));
         chk("ill64", 64'(r64_out_illegal), 64'b0);
      end
   endtask

   // One clock: check before the edge, advance the model across it.
   task automatic cycle();
      bit acc, emt;
      entry_t e;
      @(negedge clk);
      if (rst_n) check_model();
      acc = in_valid && (model_q.size() < 2);
      emt = out_ready && (model_q.size() > 0);
      e.inst = in_inst; e.src = in_imm_src; e.tag = in_tag;
      @(posedge clk);
      last_acc = acc && rst_n && !flush;
      if (!rst_n || flush) begin
         model_q.delete();
      end else begin
         if (emt) begin
            emitted.push_back(model_q[0].tag);
            void'(model_q.pop_front());
         end
         if (acc) model_q.push_back(e);
      end
      #1;
   endtask

   // Send one entry into an empty stage and compare against fixed expected values.
   task automatic send_one(string nm, logic [31:0] inst, logic [2:0] src, logic [7:0] tag,
                           logic [63:0] e32, logic [63:0] e64, logic il32);
      in_valid = 1'b1; in_inst = inst; in_imm_src = src; in_tag = tag; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk({nm, "_v"}, 64'(r32_out_valid), 64'b1);
      chk({nm, "_tag"}, 64'(r32_out_tag), 64'(tag));
      chk({nm, "_i32"}, 64'(r32_out_imm), e32);
      chk({nm, "_i64"}, r64_out_imm, e64);
      chk({nm, "_il32"}, 64'(r32_out_illegal), 64'(il32));
      chk({nm, "_il64"}, 64'(r64_out_illegal), 64'b0);
      cycle();
   endtask

   initial begin
      int cyc;
      int next_tag;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0;
      in_imm_src = '0; in_tag = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_v", 64'(r32_out_valid), 64'b0);
      chk("rst_imm64", r64_out_imm, 64'b0);
      chk("rst_tag", 64'(r32_out_tag), 64'b0);
      chk("rst_ill", 64'(r32_out_illegal), 64'b0);
      rst_n = 1'b1;
      cycle();

      // Directed vectors.
      send_one("addi", 32'hFFF00093, 3'd0, 8'h5A, 64'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
      send_one("beq",  32'hFE000EE3, 3'd2, 8'h11, 64'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
      send_one("jal",  32'h0080006F, 3'd3, 8'h12, 64'h8, 64'h8, 1'b0);
      send_one("luin", 32'h800000B7, 3'd4, 8'h13, 64'h80000000, 64'hFFFFFFFF_80000000, 1'b0);
      send_one("luip", 32'h123450B7, 3'd4, 8'h14, 64'h12345000, 64'h12345000, 1'b0);
      send_one("shmt", 32'h03F09093, 3'd5, 8'h15, 64'd31, 64'd63, 1'b1);
      send_one("zimm", 32'h000FD073, 3'd6, 8'h16, 64'd31, 64'd31, 1'b0);
      send_one("zero", 32'hFFFFFFFF, 3'd7, 8'h17, 64'd0, 64'd0, 1'b0);
      send_one("sw",   32'hFE112E23, 3'd1, 8'h18, 64'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0);

      // Backpressure: tags 1..5, out_ready low for the first 4 cycles.
      emitted.delete();
      next_tag = 1;
      cyc = 0;
      while (emitted.size() < 5 && cyc < 60) begin
         out_ready = (cyc >= 4);
         in_valid  = (next_tag <= 5);
         in_tag    = 8'(next_tag);
         in_inst   = $urandom;
         in_imm_src = 3'($urandom_range(0, 7));
         cycle();
         if (last_acc) next_tag++;
         if (cyc == 2) chk("bp_rdy_low", 64'(r32_in_ready), 64'b0);
         cyc++;
      end
      in_valid = 1'b0;
      chk("bp_count", 64'(emitted.size()), 64'd5);
      for (int k = 0; k < emitted.size(); k++) chk("bp_order", 64'(emitted[k]), 64'(k + 1));

      // Flush with both entries held and a same-cycle request.
      out_ready = 1'b0; in_valid = 1'b1;
      in_inst = 32'h00100093; in_imm_src = 3'd0;
      in_tag = 8'hA1; cycle();
      in_tag = 8'hA2; cycle();
      chk("pre_flush_rdy", 64'(r32_in_ready), 64'b0);
      flush = 1'b1; in_tag = 8'hA3; cycle();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_v", 64'(r32_out_valid), 64'b0);
      chk("flush_rdy", 64'(r64_in_ready), 64'b1);
      in_valid = 1'b1; in_tag = 8'h77; out_ready = 1'b1; cycle();
      in_valid = 1'b0;
      chk("post_flush_tag", 64'(r32_out_tag), 64'h77);
      cycle();

      // Reset with two entries held.
      out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFFF00093; in_imm_src = 3'd0;
      in_tag = 8'hC1; cycle();
      in_tag = 8'hC2; cycle();
      in_valid = 1'b0; rst_n = 1'b0; flush = 1'b1; cycle();
      flush = 1'b0;
      chk("mrst_v", 64'(r64_out_valid), 64'b0);
      chk("mrst_imm", r64_out_imm, 64'b0);
      chk("mrst_tag", 64'(r64_out_tag), 64'b0);
      chk("mrst_ill", 64'(r32_out_illegal), 64'b0);
      rst_n = 1'b1; cycle();
      chk("mrst_rdy", 64'(r32_in_ready), 64'b1);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 2) != 0);
         flush      = ($urandom_range(0, 19) == 0);
         in_inst    = $urandom;
         in_imm_src = 3'($urandom_range(0, 7));
         in_tag     = 8'($urandom);
         cycle();
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
